// File: rtl/aes_iter_core.sv
`timescale 1ns/1ps
// aes_iter_core -- iterative AES encryption engine, one round per clock.
//
// Supports AES-128/192/256 through KEY_BITS. A key load expands the full
// round-key schedule into a register array, one 32-bit word per cycle. The
// schedule is then reused for any number of blocks until the next key load.
//
// Build option: define AES_CTR_EN for counter mode. The core then encrypts an
// internal 128-bit counter (loaded from iv on every key load), XORs the
// result with the captured in_data, and steps ctr[31:0] on every accepted
// block. Without the macro the core is a plain ECB engine and has no iv port.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   key_valid/key_ready/key cipher key, FIPS-197 byte 0 = key[KEY_BITS-1 -: 8]
//   in_valid/in_ready/in_data  plaintext block, byte 0 = in_data[127:120]
//   iv                      initial counter block (AES_CTR_EN only)
//   out_valid/out_ready/out_data  ciphertext block, same byte order
//   busy                    high while expanding a key or running rounds
//   dbg_state               current FSM state (state_t encoding)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid and its data stable until that edge;
// ready never depends on the same channel's valid. The one cross-channel
// dependency: in READY, key_valid high forces in_ready low, so a key load
// always wins over a block.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
`ifdef AES_CTR_EN
  input  logic [127:0]        iv,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    READY  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // SubBytes and ShiftRows together; byte (row, col) sits at index row+4*col.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = SBOX[s[127 - 8*(row + 4*((c + row) % 4)) -: 8]];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  state_t       st, st_nxt;
  logic         alive;       // low until the first edge after reset
  logic [3:0]   rnd;
  logic [127:0] aes_state;
  logic [31:0]  w [NW];      // round-key schedule
  logic [5:0]   widx;        // word being produced during KEYEXP
  logic [3:0]   kpos;        // widx % NK, tracked incrementally
  logic [7:0]   rcon;        // Rcon for the next kpos==0 word

  logic         key_fire, in_fire, out_fire;
  logic [31:0]  w_prev, w_back, w_tmp, w_new;
  logic [127:0] rk0, rk, sr, last_val, round_val, blk, result;

`ifdef AES_CTR_EN
  logic [127:0] ctr;
  logic [127:0] din_q;
  assign blk    = ctr;
  assign result = last_val ^ din_q;
`else
  assign blk    = in_data;
  assign result = last_val;
`endif

  // Next state and handshake decode.
  always_comb begin
    st_nxt    = st;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (st)
      IDLE: begin
        key_ready = alive;
        if (key_valid && alive) st_nxt = KEYEXP;
      end
      KEYEXP: begin
        busy = 1'b1;
        if (widx == 6'(NW - 1)) st_nxt = READY;
      end
      READY: begin
        key_ready = 1'b1;
        in_ready  = !key_valid;
        if (key_valid)     st_nxt = KEYEXP;
        else if (in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd == 4'(NR)) st_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = READY;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign dbg_state = st;

  // Key expansion word generator.
  always_comb begin
    w_prev = w[widx - 6'd1];
    w_back = w[widx - 6'(NK)];
    if (kpos == 4'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && kpos == 4'd4)
      w_tmp = sub_word(w_prev);
    else
      w_tmp = w_prev;
    w_new = w_back ^ w_tmp;
  end

  // Round datapath.
  assign rk0       = {w[0], w[1], w[2], w[3]};
  assign rk        = {w[{rnd, 2'd0}], w[{rnd, 2'd1}], w[{rnd, 2'd2}], w[{rnd, 2'd3}]};
  assign sr        = sub_shift(aes_state);
  assign round_val = mix_columns(sr) ^ rk;
  assign last_val  = sr ^ rk;

  // Schedule storage carries no reset: IDLE marks it invalid.
  always_ff @(posedge clk) begin
    if (key_fire) begin
      for (int j = 0; j < NK; j++) w[j] <= key[KEY_BITS - 1 - 32*j -: 32];
    end else if (st == KEYEXP) begin
      w[widx] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      alive     <= 1'b0;
      rnd       <= 4'd0;
      widx      <= 6'd0;
      kpos      <= 4'd0;
      rcon      <= 8'h01;
      aes_state <= '0;
      out_data  <= '0;
`ifdef AES_CTR_EN
      ctr       <= '0;
      din_q     <= '0;
`endif
    end else begin
      st    <= st_nxt;
      alive <= 1'b1;
      if (key_fire) begin
        widx <= 6'(NK);
        kpos <= 4'd0;
        rcon <= 8'h01;
        rnd  <= 4'd0;
`ifdef AES_CTR_EN
        ctr  <= iv;
`endif
      end else if (st == KEYEXP) begin
        widx <= widx + 6'd1;
        kpos <= (kpos == 4'(NK - 1)) ? 4'd0 : kpos + 4'd1;
        if (kpos == 4'd0) rcon <= xtime(rcon);
      end
      if (in_fire) begin
        aes_state <= blk ^ rk0;
        rnd       <= 4'd1;
`ifdef AES_CTR_EN
        din_q     <= in_data;
        ctr[31:0] <= ctr[31:0] + 32'd1;
`endif
      end else if (st == ROUND) begin
        rnd <= rnd + 4'd1;
        if (rnd == 4'(NR)) begin
          aes_state <= last_val;
          out_data  <= result;
        end else begin
          aes_state <= round_val;
        end
      end
    end
  end

endmodule
